shift_frame_sequencer: RTL and testbench

- Controller that feeds a serial-in/parallel-out register chain (WIDTH single-bit d_register stages, serial input entering at the MSB stage).
- Accepts a parallel word over a valid/ready handshake and drives the chain's serial input and shift enable for exactly WIDTH cycles, LSB first.
- After those WIDTH cycles the word sits in the chain at its original bit positions.
- Pulses frame_done when the chain output is valid, then enforces a programmable idle gap before accepting the next word.

---
 rtl/shift_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_sequencer.sv
// Serialises a parallel word LSB-first into a serial-in/parallel-out chain, then idles GAP_CYCLES.
// Latency: first shift_en one cycle after handshake; frame_done one cycle after the last shift.
// Backpressure: in_ready only in IDLE; SHIFT_FRAME_SEQ_PARITY_EN appends an even-parity shift cycle.
module shift_frame_sequencer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             shift_en,
  output logic             serial_out,
  output logic             frame_done,
  output logic             busy
);

`ifdef SHIFT_FRAME_SEQ_PARITY_EN
  localparam int SHIFT_LEN = WIDTH + 1;
`else
  localparam int SHIFT_LEN = WIDTH;
`endif

  localparam int CNT_W  = (SHIFT_LEN > 2) ? $clog2(SHIFT_LEN) : 1;
  localparam int GCNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             done_q, done_d;
  logic             data_bit;

  // Next-state logic: handshake in IDLE, bit walk in SHIFT, idle countdown in GAP; flush aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // flush wins over acceptance: stay ready but capture nothing
        if (!flush && in_valid) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          gcnt_d  = '0;
          done_d  = 1'b1;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (flush || gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        gcnt_d  = '0;
      end
    endcase
  end

  // State, counters, holding register and frame_done pulse; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // Select hold[cnt]; a mux loop keeps the index width independent of the counter width.
  always_comb begin
    data_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) data_bit = hold_q[i];
    end
`ifdef SHIFT_FRAME_SEQ_PARITY_EN
    if (cnt_q == CNT_LAST) data_bit = ^hold_q;
`endif
  end

  // Outputs depend only on registered state, never on inputs.
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign shift_en   = (state_q == S_SHIFT);
  assign serial_out = (state_q == S_SHIFT) & data_bit;
  assign frame_done = done_q;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Bench for shift_frame_sequencer: three instances (GAP 1, 3, 0) with a downstream chain model.
// Expected outputs come from a per-frame timeline computed from the handshake cycle.
// Random words and junk inputs during busy periods exercise the ignore rules.
module tb_shift_frame_sequencer;

`ifdef SHIFT_FRAME_SEQ_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_valid = '0;
  logic [3:0] in_data [3];
  logic [2:0] flush = '0;
  logic [2:0] in_ready, shift_en, serial_out, frame_done, busy;
  logic [NB-1:0] chain [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    shift_frame_sequencer #(
      .WIDTH(4),
      .GAP_CYCLES((k == 0) ? 1 : ((k == 1) ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[k]),
      .in_data   (in_data[k]),
      .in_ready  (in_ready[k]),
      .flush     (flush[k]),
      .shift_en  (shift_en[k]),
      .serial_out(serial_out[k]),
      .frame_done(frame_done[k]),
      .busy      (busy[k])
    );
  end

  // Downstream chain: serial input enters at the MSB stage.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (shift_en[k] === 1'b1) chain[k] <= {serial_out[k], chain[k][NB-1:1]};
    end
  end

  function automatic logic [NB-1:0] expected_chain(input logic [3:0] w);
`ifdef SHIFT_FRAME_SEQ_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  // Present a word in a cycle where the sequencer must be ready.
  task automatic start_word(input int k, input logic [3:0] w, input string tag);
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    checks++;
    if (in_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s start k=%0d: in_ready got %b exp 1", tag, k, in_ready[k]);
    end
  endtask

  // Walk one frame timeline after its handshake edge; the final cycle sets up the next handshake.
  task automatic run_frame(input int k, input int g, input logic [3:0] w,
                           input bit nv, input logic [3:0] nw, input string tag);
    logic [NB-1:0] full;
    logic [4:0] exp_v, got_v;
    logic e_sh, e_so, e_dn, e_rd;
    full = expected_chain(w);
    for (int c = 1; c <= NB + g + 1; c++) begin
      @(posedge clk); #1;
      e_sh = (c <= NB);
      e_so = e_sh ? full[c-1] : 1'b0;
      e_dn = (c == NB + 1);
      e_rd = (c == NB + g + 1);
      exp_v = {e_sh, e_so, e_dn, e_rd, ~e_rd};
      got_v = {shift_en[k], serial_out[k], frame_done[k], in_ready[k], busy[k]};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s k=%0d word=%h cyc=%0d {sh,so,done,rdy,busy}: got %b exp %b",
                 tag, k, w, c, got_v, exp_v);
      end
      if (c == NB + 1) begin
        checks++;
        if (chain[k] !== full) begin
          failures++;
          $display("FAIL %s chain k=%0d: got %b exp %b", tag, k, chain[k], full);
        end
      end
      if (c < NB + g + 1) begin
        in_valid[k] = 1'($urandom);
        in_data[k]  = 4'($urandom);
      end else begin
        in_valid[k] = nv;
        in_data[k]  = nw;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({in_ready[k], busy[k], shift_en[k], serial_out[k], frame_done[k]} !== 5'b10000) begin
        failures++;
        $display("FAIL reset k=%0d {rdy,busy,sh,so,done}: got %b exp 10000", k,
                 {in_ready[k], busy[k], shift_en[k], serial_out[k], frame_done[k]});
      end
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 3'b111 || busy !== 3'b000 || frame_done !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle: rdy=%b busy=%b done=%b exp 111/000/000", in_ready, busy, frame_done);
    end
  endtask

  task automatic test_basic();
    logic [3:0] w;
    start_word(0, 4'b1011, "basic");
    run_frame(0, 1, 4'b1011, 1'b0, 4'h0, "basic");
    for (int i = 0; i < 3; i++) begin
      w = 4'($urandom);
      @(posedge clk); #1;
      start_word(0, w, "basic_rand");
      run_frame(0, 1, w, 1'b0, 4'h0, "basic_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [6];
    words[0] = 4'hA;
    words[1] = 4'h5;
    for (int i = 2; i < 6; i++) words[i] = 4'($urandom);
    start_word(1, words[0], "b2b_gap3");
    for (int i = 0; i < 6; i++)
      run_frame(1, 3, words[i], (i < 5), (i < 5) ? words[(i < 5) ? i + 1 : i] : 4'h0, "b2b_gap3");
    for (int i = 0; i < 6; i++) words[i] = 4'($urandom);
    start_word(2, words[0], "b2b_gap0");
    for (int i = 0; i < 6; i++)
      run_frame(2, 0, words[i], (i < 5), (i < 5) ? words[(i < 5) ? i + 1 : i] : 4'h0, "b2b_gap0");
  endtask

  task automatic test_flush();
    // flush in IDLE alongside a valid word: nothing is captured
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'hF;
    flush[0]    = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready[0], busy[0], shift_en[0]} !== 3'b100) begin
      failures++;
      $display("FAIL flush_idle {rdy,busy,sh}: got %b exp 100", {in_ready[0], busy[0], shift_en[0]});
    end
    flush[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    checks++;
    if ({shift_en[0], serial_out[0]} !== 2'b11) begin
      failures++;
      $display("FAIL flush_shift1 {sh,so}: got %b exp 11", {shift_en[0], serial_out[0]});
    end
    @(posedge clk); #1;
    checks++;
    if (shift_en[0] !== 1'b1) begin
      failures++;
      $display("FAIL flush_shift2 sh: got %b exp 1", shift_en[0]);
    end
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    checks++;
    if ({shift_en[0], in_ready[0], busy[0], frame_done[0]} !== 4'b0100) begin
      failures++;
      $display("FAIL flush_abort {sh,rdy,busy,done}: got %b exp 0100",
               {shift_en[0], in_ready[0], busy[0], frame_done[0]});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (frame_done[0] !== 1'b0 || shift_en[0] !== 1'b0) begin
        failures++;
        $display("FAIL flush_quiet cyc=%0d {done,sh}: got %b exp 00", i, {frame_done[0], shift_en[0]});
      end
    end
    start_word(0, 4'h3, "flush_next");
    run_frame(0, 1, 4'h3, 1'b0, 4'h0, "flush_next");
    // flush during GAP returns straight to IDLE
    start_word(1, 4'h6, "flush_gap");
    repeat (NB + 1) @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    flush[1]    = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    checks++;
    if ({in_ready[1], busy[1], frame_done[1]} !== 3'b100) begin
      failures++;
      $display("FAIL flush_gap {rdy,busy,done}: got %b exp 100", {in_ready[1], busy[1], frame_done[1]});
    end
  endtask

  task automatic test_reset_gap();
    start_word(1, 4'h9, "rst_gap");
    repeat (NB + 2) @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    checks++;
    if ({busy[1], in_ready[1], shift_en[1]} !== 3'b100) begin
      failures++;
      $display("FAIL rst_gap_pre {busy,rdy,sh}: got %b exp 100", {busy[1], in_ready[1], shift_en[1]});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready[1], busy[1], shift_en[1], serial_out[1], frame_done[1]} !== 5'b10000) begin
      failures++;
      $display("FAIL rst_gap {rdy,busy,sh,so,done}: got %b exp 10000",
               {in_ready[1], busy[1], shift_en[1], serial_out[1], frame_done[1]});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (frame_done[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
        failures++;
        $display("FAIL rst_gap_quiet cyc=%0d {done,rdy}: got %b exp 01", i, {frame_done[1], in_ready[1]});
      end
    end
    start_word(1, 4'hC, "rst_gap_next");
    run_frame(1, 3, 4'hC, 1'b0, 4'h0, "rst_gap_next");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) in_data[k] = 4'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_reset_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
